// File: rtl/ddr_buf_pkg.sv
// Shared constants and types for the DDR frame-buffer reader and writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ddr_buf_pkg;

    localparam int BURST_LEN        = 32;     // beats per burst, also the address step
    localparam int BURSTS_PER_LINE  = 20;     // 640 beats of 64 bits per video line
    localparam int BURSTS_PER_FRAME = 14400;  // 720 lines
    localparam int FIFO_DEPTH       = 1024;   // downstream FIFO depth, 64-bit words

    typedef logic [28:0] ddr_addr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_CREDIT,
        ST_REQ,
        ST_DRAIN
    } rd_state_t;

endpackage

// File: rtl/read_frame_rx_tagger.sv
// Return-path register stage: tags each returned beat with line/frame markers.
// Latency: 1 cycle from beat_vld/beat_dat to out_valid/out_data.
// Backpressure: none; upstream credit guarantees the consumer always has room.
//
// Ports: clk/rst_n (async active-low), clear (restart counters at frame start),
// beat_vld/beat_dat (accepted return beat), out_* stream with sof/eof/sol/eol,
// end_frame (pulse with the final beat of the frame).
module read_frame_rx_tagger
#(
    parameter int BURSTS_PER_LINE  = ddr_buf_pkg::BURSTS_PER_LINE,
    parameter int BURSTS_PER_FRAME = ddr_buf_pkg::BURSTS_PER_FRAME
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        beat_vld,
    input  logic [63:0] beat_dat,
    output logic [63:0] out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_sol,
    output logic        out_eol,
    output logic        end_frame
);
    import ddr_buf_pkg::*;

    localparam int BEAT_W  = $clog2(BURST_LEN);
    localparam int LINE_W  = (BURSTS_PER_LINE  > 1) ? $clog2(BURSTS_PER_LINE)  : 1;
    localparam int FRAME_W = (BURSTS_PER_FRAME > 1) ? $clog2(BURSTS_PER_FRAME) : 1;

    logic [BEAT_W-1:0]  beat_cnt;
    logic [LINE_W-1:0]  line_burst;
    logic [FRAME_W-1:0] rx_burst;

    logic first_beat, last_beat;
    logic line_first, line_last, frame_first, frame_last;

    assign first_beat  = (beat_cnt == '0);
    assign last_beat   = (beat_cnt == BEAT_W'(BURST_LEN - 1));
    assign line_first  = (line_burst == '0);
    assign line_last   = (line_burst == LINE_W'(BURSTS_PER_LINE - 1));
    assign frame_first = (rx_burst == '0);
    assign frame_last  = (rx_burst == FRAME_W'(BURSTS_PER_FRAME - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            out_sol    <= 1'b0;
            out_eol    <= 1'b0;
            end_frame  <= 1'b0;
            beat_cnt   <= '0;
            line_burst <= '0;
            rx_burst   <= '0;
        end else begin
            // Markers are gated by beat_vld so they are never set on an idle cycle.
            out_valid <= beat_vld;
            out_sol   <= beat_vld & first_beat & line_first;
            out_eol   <= beat_vld & last_beat  & line_last;
            out_sof   <= beat_vld & first_beat & frame_first;
            out_eof   <= beat_vld & last_beat  & frame_last;
            end_frame <= beat_vld & last_beat  & frame_last;
            if (beat_vld) begin
                out_data <= beat_dat;
            end

            if (clear) begin
                beat_cnt   <= '0;
                line_burst <= '0;
                rx_burst   <= '0;
            end else if (beat_vld) begin
                beat_cnt <= beat_cnt + BEAT_W'(1);   // BURST_LEN is a power of two: wraps naturally
                if (last_beat) begin
                    line_burst <= line_last  ? '0 : line_burst + LINE_W'(1);
                    rx_burst   <= frame_last ? '0 : rx_burst + FRAME_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/read_from_buf_frame.sv
// Reads one stored frame from DDR as fixed-length Avalon-MM read bursts and streams it out.
// Latency: 1 cycle from avm_readdatavalid to out_valid; a request follows credit by 1 cycle.
// Backpressure: none on the output; bursts are only issued when the downstream FIFO has room.
//
// Ports: clk_100/reset_n (async active-low), start_frame pulse + reg_addr_buf_1 base address,
// avm_* burst read master, fifo_usedw downstream fill level, out_* 64-bit stream with
// sof/eof/sol/eol, busy, end_frame pulse, protocol_err (sticky unexpected return beat).
module read_from_buf_frame
#(
    parameter int BURSTS_PER_LINE  = ddr_buf_pkg::BURSTS_PER_LINE,
    parameter int BURSTS_PER_FRAME = ddr_buf_pkg::BURSTS_PER_FRAME,
    parameter int FIFO_DEPTH       = ddr_buf_pkg::FIFO_DEPTH
) (
    input  logic        clk_100,
    input  logic        reset_n,
    input  logic        start_frame,
    input  logic [31:0] reg_addr_buf_1,
    output logic [28:0] avm_address,
    output logic        avm_read,
    output logic [6:0]  avm_burstcount,
    input  logic        avm_waitrequest,
    input  logic [63:0] avm_readdata,
    input  logic        avm_readdatavalid,
    input  logic [10:0] fifo_usedw,
    output logic [63:0] out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_sol,
    output logic        out_eol,
    output logic        busy,
    output logic        end_frame,
    output logic        protocol_err
);
    import ddr_buf_pkg::*;

    localparam int REQ_W = $clog2(BURSTS_PER_FRAME + 1);

    rd_state_t        state;
    logic [REQ_W-1:0] req_cnt;
    logic [10:0]      outstanding;   // beats requested but not yet returned
    logic [11:0]      credit_need;
    logic             credit_ok;
    logic             accept;
    logic             beat_ok;
    logic             start_ok;
    logic             unused_addr_bits;

    assign avm_burstcount   = 7'(BURST_LEN);
    assign unused_addr_bits = ^reg_addr_buf_1[31:29];

    // avm_read is only ever high in ST_REQ, so this is the burst-accept strobe.
    assign accept   = avm_read & ~avm_waitrequest;
    // A beat with nothing outstanding cannot belong to us (e.g. survivor of a reset).
    assign beat_ok  = avm_readdatavalid & (outstanding != '0);
    assign start_ok = (state == ST_IDLE) & start_frame;

    // Room must exist for everything already in flight plus the new burst.
    assign credit_need = {1'b0, fifo_usedw} + {1'b0, outstanding} + 12'(BURST_LEN);
    assign credit_ok   = (credit_need <= 12'(FIFO_DEPTH));

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else begin
            case ({accept, beat_ok})
                2'b10:   outstanding <= outstanding + 11'(BURST_LEN);
                2'b01:   outstanding <= outstanding - 11'd1;
                2'b11:   outstanding <= outstanding + 11'(BURST_LEN - 1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            protocol_err <= 1'b0;
        end else if (avm_readdatavalid && (outstanding == '0)) begin
            protocol_err <= 1'b1;
        end else if (start_ok) begin
            protocol_err <= 1'b0;
        end
    end

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            avm_address <= '0;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            req_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_frame) begin
                        avm_address <= reg_addr_buf_1[28:0];
                        req_cnt     <= '0;
                        busy        <= 1'b1;
                        state       <= ST_WAIT_CREDIT;
                    end
                end
                ST_WAIT_CREDIT: begin
                    if (credit_ok) begin
                        avm_read <= 1'b1;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Address and read stay untouched while the slave stalls.
                    if (!avm_waitrequest) begin
                        avm_read    <= 1'b0;
                        avm_address <= avm_address + 29'(BURST_LEN);
                        req_cnt     <= req_cnt + REQ_W'(1);
                        state       <= (req_cnt == REQ_W'(BURSTS_PER_FRAME - 1)) ? ST_DRAIN
                                                                                : ST_WAIT_CREDIT;
                    end
                end
                ST_DRAIN: begin
                    // The beat that took outstanding to zero is on the output this cycle,
                    // so by the time we leave it has been presented downstream.
                    if (outstanding == '0) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    read_frame_rx_tagger #(
        .BURSTS_PER_LINE  (BURSTS_PER_LINE),
        .BURSTS_PER_FRAME (BURSTS_PER_FRAME)
    ) u_rx_tagger (
        .clk       (clk_100),
        .rst_n     (reset_n),
        .clear     (start_ok),
        .beat_vld  (beat_ok),
        .beat_dat  (avm_readdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .out_sol   (out_sol),
        .out_eol   (out_eol),
        .end_frame (end_frame)
    );

endmodule

// File: tb/tb_read_from_buf_frame.sv
// Directed bench for read_from_buf_frame with a shortened frame (6 bursts, 2 per line).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: the bench plays a zero-latency DDR slave with optional waitrequest stalls.
module tb_read_from_buf_frame;

    localparam int BL    = 32;
    localparam int L     = 2;
    localparam int F     = 6;
    localparam int TOTAL = F * BL;

    logic        clk_100 = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_frame = 1'b0;
    logic [31:0] reg_addr_buf_1 = '0;
    logic [28:0] avm_address;
    logic        avm_read;
    logic [6:0]  avm_burstcount;
    logic        avm_waitrequest = 1'b0;
    logic [63:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic [10:0] fifo_usedw = '0;
    logic [63:0] out_data;
    logic        out_valid, out_sof, out_eof, out_sol, out_eol;
    logic        busy, end_frame, protocol_err;

    int n_checks = 0;
    int n_err    = 0;

    read_from_buf_frame #(
        .BURSTS_PER_LINE  (L),
        .BURSTS_PER_FRAME (F),
        .FIFO_DEPTH       (1024)
    ) dut (
        .clk_100           (clk_100),
        .reset_n           (reset_n),
        .start_frame       (start_frame),
        .reg_addr_buf_1    (reg_addr_buf_1),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_burstcount    (avm_burstcount),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .fifo_usedw        (fifo_usedw),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_sof           (out_sof),
        .out_eof           (out_eof),
        .out_sol           (out_sol),
        .out_eol           (out_eol),
        .busy              (busy),
        .end_frame         (end_frame),
        .protocol_err      (protocol_err)
    );

    always #5 clk_100 = ~clk_100;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    // Runs a whole frame against a zero-latency slave that returns one beat per cycle
    // whenever it owes beats. stall_burst selects a burst whose request is held off
    // with waitrequest for 5 cycles (-1 for none).
    task automatic run_frame(input logic [31:0] base, input int stall_burst, input string nm);
        int issued = 0, sent = 0, emitted = 0, pending = 0, stall_cnt = 0;
        int sof_n = 0, eof_n = 0, sol_n = 0, eol_n = 0, ef_n = 0, sim_n = 0, prev_out = 0;
        int beat, burst;
        bit acc_next = 0, rdv_prev = 0, sim_prev = 0, want_drop = 0, done = 0, stalling = 0;
        logic [63:0] dat_prev = '0;
        logic [5:0]  exp_mk;
        logic [28:0] exp_addr;

        reg_addr_buf_1 = base;
        start_frame    = 1'b1;
        tick();
        start_frame = 1'b0;
        check({nm, "_start"}, 128'({busy, protocol_err, avm_read, avm_address}),
              128'({1'b1, 1'b0, 1'b0, base[28:0]}));

        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            tick();
            if (acc_next) begin
                pending += BL;
                issued++;
            end
            if (sim_prev) begin
                sim_n++;
                check("sim_accept_beat", 128'(dut.outstanding), 128'(prev_out + 31));
            end
            check("outstanding", 128'(dut.outstanding), 128'(pending));
            if (stalling)
                check("stall_hold_read", 128'(avm_read), 128'(1));

            sof_n += int'(out_sof);
            eof_n += int'(out_eof);
            sol_n += int'(out_sol);
            eol_n += int'(out_eol);
            ef_n  += int'(end_frame);

            if (want_drop) begin
                check("busy_drop", 128'(busy), 128'(0));
                done = 1;
            end
            if (rdv_prev) begin
                beat   = emitted % BL;
                burst  = emitted / BL;
                exp_mk = {1'b1, emitted == 0, emitted == TOTAL - 1,
                          beat == 0 && burst % L == 0, beat == BL - 1 && burst % L == L - 1,
                          emitted == TOTAL - 1};
                check("beat", 128'({out_data, out_valid, out_sof, out_eof, out_sol, out_eol, end_frame}),
                      128'({dat_prev, exp_mk}));
                if (emitted == TOTAL - 1) begin
                    check("busy_last_beat", 128'(busy), 128'(1));
                    want_drop = 1;
                end
                emitted++;
            end else begin
                check("idle_out", 128'({out_valid, out_sof, out_eof, out_sol, out_eol, end_frame}),
                      128'(0));
            end

            if (!done) begin
                prev_out        = pending;
                acc_next        = 0;
                stalling        = 0;
                avm_waitrequest = 1'b0;
                if (pending > 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = {32'(sent) ^ 32'hC0DE_0000, ~32'(sent)};
                    dat_prev          = avm_readdata;
                    sent++;
                    pending--;
                end else begin
                    avm_readdatavalid = 1'b0;
                end
                rdv_prev = avm_readdatavalid;
                if (avm_read) begin
                    exp_addr = 29'(base[28:0] + 29'(issued * BL));
                    check("addr", 128'(avm_address), 128'(exp_addr));
                    check("req_in_range", 128'(issued < F), 128'(1));
                    if (issued == stall_burst && stall_cnt < 5) begin
                        avm_waitrequest = 1'b1;
                        stall_cnt++;
                        stalling = 1;
                    end else begin
                        acc_next = 1;
                    end
                end
                sim_prev = acc_next && rdv_prev;
                // A start pulse with a different base while busy must change nothing.
                start_frame    = (cyc == 20);
                reg_addr_buf_1 = (cyc == 20) ? 32'h0ABC_0000 : base;
            end
        end

        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;
        start_frame       = 1'b0;
        check({nm, "_done"},   128'(done),   128'(1));
        check({nm, "_issued"}, 128'(issued), 128'(F));
        check({nm, "_sent"},   128'(sent),   128'(TOTAL));
        check({nm, "_sof_n"},  128'(sof_n),  128'(1));
        check({nm, "_eof_n"},  128'(eof_n),  128'(1));
        check({nm, "_ef_n"},   128'(ef_n),   128'(1));
        check({nm, "_sol_n"},  128'(sol_n),  128'(F / L));
        check({nm, "_eol_n"},  128'(eol_n),  128'(F / L));
        check({nm, "_sim_seen"}, 128'(sim_n > 0), 128'(1));
        if (stall_burst >= 0)
            check({nm, "_stall_cycles"}, 128'(stall_cnt), 128'(5));
    endtask

    initial begin
        // Reset state, sampled while reset is held.
        #12;
        check("rst_ctrl", 128'({avm_address, avm_read, avm_burstcount, out_valid, out_sof, out_eof,
                                out_sol, out_eol, busy, end_frame, protocol_err}),
              128'({29'h0, 1'b0, 7'd32, 8'h00}));
        check("rst_data", 128'(out_data), 128'(0));
        #10 reset_n = 1'b1;
        tick();

        // Frame A: normal base, stalled request on burst 2, ignored restart mid-frame.
        run_frame(32'h0000_1000, 2, "fa");

        // Credit gating: 993 + 32 > 1024 blocks, 992 + 32 == 1024 allows.
        fifo_usedw     = 11'd993;
        reg_addr_buf_1 = 32'h0000_2000;
        start_frame    = 1'b1;
        tick();
        start_frame = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("credit_block", 128'(avm_read), 128'(0));
        end
        fifo_usedw = 11'd992;
        tick();
        check("credit_open", 128'({avm_read, avm_address}), 128'({1'b1, 29'h0000_2000}));
        tick();
        check("credit_accept", 128'({avm_read, dut.outstanding, avm_address}),
              128'({1'b0, 11'd32, 29'h0000_2020}));

        // Abort mid-frame with beats still owed by the slave.
        reset_n = 1'b0;
        #1;
        check("rst_mid", 128'({avm_address, avm_read, avm_burstcount, out_valid, out_sof, out_eof,
                               out_sol, out_eol, busy, end_frame, protocol_err}),
              128'({29'h0, 1'b0, 7'd32, 8'h00}));
        check("rst_mid_outstanding", 128'(dut.outstanding), 128'(0));
        @(negedge clk_100);
        reset_n    = 1'b1;
        fifo_usedw = 11'd0;
        tick();
        avm_readdatavalid = 1'b1;
        avm_readdata      = 64'hDEAD_BEEF_0BAD_F00D;
        tick();
        avm_readdatavalid = 1'b0;
        check("stray_beat", 128'({out_valid, protocol_err, busy, avm_read}), 128'(4'b0100));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("err_sticky", 128'({protocol_err, out_valid}), 128'(2'b10));
        end

        // Frame B: base at the top of the 29-bit space, second burst wraps to 0.
        run_frame(32'h1FFF_FFE0, -1, "fb");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
